// File: rtl/countdown_timer_ctrl.sv
// MM:SS BCD countdown for the irrigation valve: loads a preset, divides the clock down to a 1 s tick,
// and decrements the digit chain with borrow ripple, pulsing done when the count reaches 00:00.
module countdown_timer_ctrl #(
    parameter int PRESCALE = 50_000_000,
    parameter int PW       = 26
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] preset,
    input  logic        start,
    input  logic        pause,
    output logic [15:0] digits,
    output logic        running,
    output logic        done,
    output logic        load_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READY  = 2'd1,
        RUN    = 2'd2,
        PAUSED = 2'd3
    } state_t;

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    state_t        state_q,    state_d;
    logic [PW-1:0] presc_q,    presc_d;
    logic [15:0]   digits_q,   digits_d;
    logic          running_q,  running_d;
    logic          done_q,     done_d;
    logic          load_err_q, load_err_d;

    logic          load_ok;
    logic          pause_ok;
    logic          tick;

    function automatic logic preset_valid(input logic [15:0] p);
        return (p[15:12] <= 4'd9) && (p[11:8] <= 4'd9) &&
               (p[7:4]   <= 4'd5) && (p[3:0]  <= 4'd9);
    endfunction

    // Only called with a non-zero count, so min_tens never underflows.
    function automatic logic [15:0] bcd_dec(input logic [15:0] d);
        logic [15:0] r;
        logic        borrow;
        r      = d;
        borrow = 1'b1;
        if (d[3:0] == 4'd0) begin
            r[3:0] = 4'd9;
        end else begin
            r[3:0] = d[3:0] - 4'd1;
            borrow = 1'b0;
        end
        if (borrow) begin
            if (d[7:4] == 4'd0) begin
                r[7:4] = 4'd5;
            end else begin
                r[7:4] = d[7:4] - 4'd1;
                borrow = 1'b0;
            end
        end
        if (borrow) begin
            if (d[11:8] == 4'd0) begin
                r[11:8] = 4'd9;
            end else begin
                r[11:8] = d[11:8] - 4'd1;
                borrow  = 1'b0;
            end
        end
        if (borrow) begin
            r[15:12] = d[15:12] - 4'd1;
        end
        return r;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            digits_q   <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            digits_q   <= digits_d;
            running_q  <= running_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign load_ok  = load && preset_valid(preset);
    assign pause_ok = !load && !start && pause && (state_q == RUN);
    assign tick     = (presc_q == PRESC_LAST);

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        digits_d   = digits_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;

        if (load) begin
            if (load_ok) begin
                digits_d = preset;
                presc_d  = '0;
                state_d  = (preset == 16'h0000) ? IDLE : READY;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (start) begin
            if ((state_q == READY) || (state_q == PAUSED)) begin
                state_d = RUN;
            end
        end else if (pause_ok) begin
            state_d = PAUSED;
        end

        // A rejected preset or an ignored start does not disturb a run in progress.
        if ((state_q == RUN) && !load_ok && !pause_ok) begin
            if (tick) begin
                presc_d = '0;
                if (digits_q == 16'h0001) begin
                    digits_d = 16'h0000;
                    state_d  = IDLE;
                    done_d   = 1'b1;
                end else if (digits_q == 16'h0000) begin
                    state_d = IDLE;
                end else begin
                    digits_d = bcd_dec(digits_q);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        running_d = (state_d == RUN);
    end

    assign digits   = digits_q;
    assign running  = running_q;
    assign done     = done_q;
    assign load_err = load_err_q;

endmodule
